// File: rtl/pllrc_pkg.sv
// pllrc_pkg: shared types and constants for the PLL reconfiguration sequencer.
//   - pllrc_state_e : sequencer FSM states
//   - pllrc_entry_t : one reconfiguration write (address, NTSC data, PAL data)
//   - PLLRC_TABLE   : the ordered register writes issued for every reprogramming
//   - pllrc_entry() : lint-safe table lookup by a 3-bit index
//   - pllrc_data()  : picks the data word for the requested standard
package pllrc_pkg;

    localparam int unsigned PLLRC_N_REGS = 6;

    typedef enum logic [2:0] {
        StBoot,
        StIdle,
        StWrite,
        StWaitLock,
        StSettle
    } pllrc_state_e;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data_ntsc;
        logic [31:0] data_pal;
    } pllrc_entry_t;

    // Order matters: waitrequest mode first, start last.
    localparam pllrc_entry_t PLLRC_TABLE [PLLRC_N_REGS] = '{
        '{addr: 6'd0, data_ntsc: 32'h0000_0000, data_pal: 32'h0000_0000},  // mode
        '{addr: 6'd3, data_ntsc: 32'h0001_0000, data_pal: 32'h0001_0000},  // N
        '{addr: 6'd4, data_ntsc: 32'h0000_0404, data_pal: 32'h0000_0404},  // M
        '{addr: 6'd5, data_ntsc: 32'h0000_0505, data_pal: 32'h0002_0504},  // C0
        '{addr: 6'd7, data_ntsc: 32'h9745_BF27, data_pal: 32'hA3D7_09E8},  // M-frac
        '{addr: 6'd2, data_ntsc: 32'h0000_0000, data_pal: 32'h0000_0000}   // start
    };

    function automatic pllrc_entry_t pllrc_entry(input logic [2:0] idx);
        pllrc_entry = PLLRC_TABLE[0];
        for (int i = 0; i < PLLRC_N_REGS; i++) begin
            if (idx == 3'(i)) begin
                pllrc_entry = PLLRC_TABLE[i];
            end
        end
    endfunction

    function automatic logic [31:0] pllrc_data(input pllrc_entry_t e, input logic is_pal);
        return is_pal ? e.data_pal : e.data_ntsc;
    endfunction

endpackage

// File: rtl/pllrc_sync.sv
// pllrc_sync: two-flop synchronizer for a single asynchronous level.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears both stages to 0
//   d_i   : asynchronous input
//   q_o   : synchronized output (two clk_i cycles of latency)
module pllrc_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reconf_seq.sv
// pll_reconf_seq: reprograms the system PLL over its Avalon-MM reconfiguration port whenever
// the requested video standard (NTSC/PAL) differs from the one last applied, and holds the
// core in tv_reset until the PLL has been rewritten, has relocked and has settled.
//   mgmt_clk, mgmt_reset   : 50 MHz management clock, asynchronous active-high reset
//   pal, pll_locked        : asynchronous status inputs (synchronized here)
//   mgmt_waitrequest       : Avalon-MM waitrequest from the reconfiguration block
//   mgmt_write/_address/_writedata : Avalon-MM write master
//   tv_reset               : core reset, low only while idle with the standard applied
//   busy                   : high whenever the sequencer is not idle
// Build option: define PLLRC_LOCK_TIMEOUT_EN to retry the whole write sequence when lock is
// not regained within LOCK_TIMEOUT cycles; otherwise the sequencer waits for lock forever.
module pll_reconf_seq
    import pllrc_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT  = 1048576
) (
    input  logic        mgmt_clk,
    input  logic        mgmt_reset,
    input  logic        pal,
    input  logic        pll_locked,
    input  logic        mgmt_waitrequest,
    output logic        mgmt_write,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        tv_reset,
    output logic        busy
);

    localparam int unsigned SettleW    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [4:0]  DropWindow = 5'd16;

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end
    if (LOCK_TIMEOUT < 1) begin : g_bad_timeout
        $error("LOCK_TIMEOUT must be at least 1");
    end

    logic pal_s;
    logic lock_s;

    pllrc_sync u_sync_pal (
        .clk_i (mgmt_clk),
        .rst_i (mgmt_reset),
        .d_i   (pal),
        .q_o   (pal_s)
    );

    pllrc_sync u_sync_lock (
        .clk_i (mgmt_clk),
        .rst_i (mgmt_reset),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    pllrc_state_e       state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic               target_std_q, target_std_d;
    logic               applied_std_q, applied_std_d;
    logic               tv_reset_q, tv_reset_d;
    logic               busy_q, busy_d;
    logic               write_q, write_d;
    logic [5:0]         addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [4:0]         drop_win_q, drop_win_d;
    logic               seen_low_q, seen_low_d;
    pllrc_entry_t       cur_entry;

`ifdef PLLRC_LOCK_TIMEOUT_EN
    localparam int unsigned TimeoutW = $clog2(LOCK_TIMEOUT + 1);
    logic [TimeoutW-1:0] timeout_q, timeout_d;
`endif

    assign cur_entry = pllrc_entry(idx_q);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        target_std_d  = target_std_q;
        applied_std_d = applied_std_q;
        // Only the IDLE hold path clears tv_reset; every other path keeps the core in reset.
        tv_reset_d    = 1'b1;
        write_d       = write_q;
        addr_d        = addr_q;
        data_d        = data_q;
        settle_d      = settle_q;
        drop_win_d    = drop_win_q;
        seen_low_d    = seen_low_q;
`ifdef PLLRC_LOCK_TIMEOUT_EN
        timeout_d     = timeout_q;
`endif

        unique case (state_q)
            StBoot: begin
                // Always reprogram after reset so an interrupted sequence is never left behind.
                target_std_d = pal_s;
                idx_d        = 3'd0;
                state_d      = StWrite;
            end
            StIdle: begin
                if (pal_s != applied_std_q) begin
                    target_std_d = pal_s;
                    idx_d        = 3'd0;
                    state_d      = StWrite;
                end else begin
                    tv_reset_d = 1'b0;
                end
            end
            StWrite: begin
                if (!write_q) begin
                    // Present the entry; the idle cycle before this is the inter-write gap.
                    write_d = 1'b1;
                    addr_d  = cur_entry.addr;
                    data_d  = pllrc_data(cur_entry, target_std_q);
                end else if (!mgmt_waitrequest) begin
                    write_d = 1'b0;
                    if (idx_q == 3'(PLLRC_N_REGS - 1)) begin
                        state_d    = StWaitLock;
                        drop_win_d = 5'd0;
                        seen_low_d = 1'b0;
`ifdef PLLRC_LOCK_TIMEOUT_EN
                        timeout_d  = '0;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StWaitLock: begin
                if (!lock_s) begin
                    seen_low_d = 1'b1;
                end
                if (drop_win_q != DropWindow) begin
                    drop_win_d = drop_win_q + 5'd1;
                end
                // A PLL that never visibly loses lock is accepted once the drop window expires.
                if (lock_s && (seen_low_q || drop_win_q == DropWindow)) begin
                    state_d  = StSettle;
                    settle_d = '0;
                end
`ifdef PLLRC_LOCK_TIMEOUT_EN
                else if (timeout_q == TimeoutW'(LOCK_TIMEOUT - 1)) begin
                    state_d = StWrite;
                    idx_d   = 3'd0;
                end else begin
                    timeout_d = timeout_q + 1'b1;
                end
`endif
            end
            StSettle: begin
                if (settle_q == SettleW'(SETTLE_CYCLES - 1)) begin
                    applied_std_d = target_std_q;
                    state_d       = StIdle;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
        if (mgmt_reset) begin
            state_q       <= StBoot;
            idx_q         <= 3'd0;
            target_std_q  <= 1'b0;
            applied_std_q <= 1'b0;
            tv_reset_q    <= 1'b1;
            busy_q        <= 1'b1;
            write_q       <= 1'b0;
            addr_q        <= 6'd0;
            data_q        <= 32'd0;
            settle_q      <= '0;
            drop_win_q    <= 5'd0;
            seen_low_q    <= 1'b0;
`ifdef PLLRC_LOCK_TIMEOUT_EN
            timeout_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            target_std_q  <= target_std_d;
            applied_std_q <= applied_std_d;
            tv_reset_q    <= tv_reset_d;
            busy_q        <= busy_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            settle_q      <= settle_d;
            drop_win_q    <= drop_win_d;
            seen_low_q    <= seen_low_d;
`ifdef PLLRC_LOCK_TIMEOUT_EN
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign mgmt_write     = write_q;
    assign mgmt_address   = addr_q;
    assign mgmt_writedata = data_q;
    assign tv_reset       = tv_reset_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_pll_reconf_seq.sv
// Self-checking bench for pll_reconf_seq: directed steps with randomized waitrequest and
// standard changes, checked against a transaction-level model of the expected write list.
module tb_pll_reconf_seq;

    localparam int unsigned SETTLE   = 20;
    localparam int unsigned TIMEOUT  = 100;
    localparam int          LOCK_LOW = 5;

    logic        mgmt_clk = 1'b0;
    logic        mgmt_reset;
    logic        pal;
    logic        pll_locked;
    logic        mgmt_waitrequest;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        tv_reset;
    logic        busy;

    always #5 mgmt_clk = ~mgmt_clk;

    pll_reconf_seq #(
        .SETTLE_CYCLES (SETTLE),
        .LOCK_TIMEOUT  (TIMEOUT)
    ) dut (
        .mgmt_clk         (mgmt_clk),
        .mgmt_reset       (mgmt_reset),
        .pal              (pal),
        .pll_locked       (pll_locked),
        .mgmt_waitrequest (mgmt_waitrequest),
        .mgmt_write       (mgmt_write),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .tv_reset         (tv_reset),
        .busy             (busy)
    );

    int tests;
    int fails;
    int cyc;
    int lock_low;
    int stall_left;
    int stall_addr;
    int stall_seen;
    bit stall_done;
    int gap_st;
    bit pll_stuck;
    bit rand_wait;
    int toggle_addr;
    logic toggle_val;
    int lock_rise_cyc;
    int tv_fall_cyc;
    int start_hs_cyc;
    logic prev_write;
    logic prev_wait;
    logic [5:0] prev_addr;
    logic [31:0] prev_data;
    logic applied_ref;

    logic [37:0] exp_q[$];
    logic [37:0] got_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // The register writes one reprogramming must produce, in order.
    function automatic logic [37:0] ref_write(input int i, input logic is_pal);
        case (i)
            0:       return {6'd0, 32'h0000_0000};
            1:       return {6'd3, 32'h0001_0000};
            2:       return {6'd4, 32'h0000_0404};
            3:       return {6'd5, is_pal ? 32'h0002_0504 : 32'h0000_0505};
            4:       return {6'd7, is_pal ? 32'hA3D7_09E8 : 32'h9745_BF27};
            default: return {6'd2, 32'h0000_0000};
        endcase
    endfunction

    task automatic expect_seq(input logic is_pal);
        for (int i = 0; i < 6; i++) exp_q.push_back(ref_write(i, is_pal));
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // One clock cycle: PLL/slave model, protocol checks, capture, then advance.
    task automatic step();
        logic new_lock;
        new_lock = !pll_stuck && (lock_low == 0);
        if (lock_low > 0) lock_low--;
        if (new_lock && !pll_locked) lock_rise_cyc = cyc;
        pll_locked = new_lock;

        if (prev_write && prev_wait) begin
            check("stall_hold", {mgmt_write, mgmt_address, mgmt_writedata},
                  {1'b1, prev_addr, prev_data});
        end
        if (gap_st == 1) begin
            check("gap_low", 64'(mgmt_write), 64'(1'b0));
            gap_st = 2;
        end else if (gap_st == 2) begin
            check("gap_rise", 64'(mgmt_write), 64'(1'b1));
            gap_st = 0;
        end

        if (mgmt_write && stall_addr >= 0 && int'(mgmt_address) == stall_addr && !stall_done) begin
            stall_left = 7;
            stall_done = 1;
        end
        if (stall_left > 0) begin
            mgmt_waitrequest = 1'b1;
            stall_left--;
            if (mgmt_write) stall_seen++;
        end else begin
            mgmt_waitrequest = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
        end

        if (mgmt_write && !mgmt_waitrequest) begin
            got_q.push_back({mgmt_address, mgmt_writedata});
            if (mgmt_address == 6'd2) begin
                lock_low     = LOCK_LOW;
                start_hs_cyc = cyc;
            end else begin
                gap_st = 1;
            end
            if (toggle_addr >= 0 && int'(mgmt_address) == toggle_addr) begin
                pal         = toggle_val;
                toggle_addr = -1;
            end
        end

        prev_write = mgmt_write;
        prev_wait  = mgmt_waitrequest;
        prev_addr  = mgmt_address;
        prev_data  = mgmt_writedata;
        @(posedge mgmt_clk);
        #1;
        cyc++;
    endtask

    // Step until tv_reset has been high and then falls; a blown budget is a failure.
    task automatic run_until_idle(input string tag, input int budget);
        bit seen_high;
        int n;
        seen_high = 0;
        for (n = 0; n < budget; n++) begin
            if (tv_reset) seen_high = 1;
            else if (seen_high) break;
            step();
        end
        tv_fall_cyc = cyc;
        check({tag, "_done"}, 64'(n < budget), 64'(1'b1));
    endtask

    task automatic idle_quiet(input string tag);
        repeat (8) step();
        check({tag, "_nowrite"}, 64'(got_q.size()), 64'd0);
        check({tag, "_tvlow"}, 64'(tv_reset), 64'(1'b0));
        got_q.delete();
    endtask

    initial begin
        int n;
        logic newpal;
        tests = 0; fails = 0; cyc = 0;
        lock_low = 0; stall_left = 0; stall_addr = -1; stall_seen = 0; stall_done = 0;
        gap_st = 0; pll_stuck = 0; rand_wait = 0; toggle_addr = -1; toggle_val = 1'b0;
        lock_rise_cyc = 0; tv_fall_cyc = 0; start_hs_cyc = -1;
        prev_write = 0; prev_wait = 0; prev_addr = '0; prev_data = '0;
        mgmt_reset = 1'b1; pal = 1'b0; pll_locked = 1'b1; mgmt_waitrequest = 1'b0;

        repeat (2) @(posedge mgmt_clk);
        #1;
        check("rst_tv_reset", 64'(tv_reset), 64'(1'b1));
        check("rst_busy", 64'(busy), 64'(1'b1));
        check("rst_write", 64'(mgmt_write), 64'(1'b0));
        check("rst_addr", 64'(mgmt_address), 64'd0);
        check("rst_data", 64'(mgmt_writedata), 64'd0);
        mgmt_reset = 1'b0;

        // Boot sequence, NTSC, no waitrequest.
        expect_seq(1'b0);
        run_until_idle("boot", 400);
        compare_writes("boot");
        // 2 sync cycles + 1 detect + SETTLE + 1 registered tv_reset
        check("boot_settle_time", 64'(tv_fall_cyc - lock_rise_cyc), 64'(SETTLE + 4));
        check("boot_busy_idle", 64'(busy), 64'(1'b0));
        applied_ref = 1'b0;
        idle_quiet("boot_idle");

        // NTSC -> PAL launch latency, then randomized waitrequest.
        pal = 1'b1;
        step();
        step();
        check("launch_tv_before", 64'(tv_reset), 64'(1'b0));
        step();
        check("launch_tv_rise", 64'(tv_reset), 64'(1'b1));
        check("launch_busy", 64'(busy), 64'(1'b1));
        step();
        check("launch_write", {mgmt_write, mgmt_address}, {1'b1, 6'd0});
        rand_wait = 1;
        expect_seq(1'b1);
        run_until_idle("pal", 400);
        compare_writes("pal");
        applied_ref = 1'b1;

        // Seven-cycle stall on the M write.
        rand_wait = 0; stall_addr = 4; stall_done = 0; stall_seen = 0;
        pal = 1'b0;
        expect_seq(1'b0);
        run_until_idle("stall", 400);
        compare_writes("stall");
        check("stall_cycles", 64'(stall_seen), 64'd7);
        check("stall_settle_time", 64'(tv_fall_cyc - lock_rise_cyc), 64'(SETTLE + 4));
        stall_addr = -1;
        applied_ref = 1'b0;

        // PAL launched, request flips back to NTSC during C0: PAL completes, NTSC follows.
        rand_wait = 1; toggle_addr = 5; toggle_val = 1'b0;
        pal = 1'b1;
        expect_seq(1'b1);
        expect_seq(1'b0);
        run_until_idle("toggle", 800);
        compare_writes("toggle");
        applied_ref = 1'b0;
        idle_quiet("toggle_idle");

        // Reset during the M-frac write of a PAL sequence.
        rand_wait = 0;
        pal = 1'b1;
        n = 0;
        while (!(mgmt_write && mgmt_address == 6'd7) && n < 200) begin
            step();
            n++;
        end
        check("rst_mid_reach", 64'(n < 200), 64'(1'b1));
        mgmt_waitrequest = 1'b1;
        #2;
        mgmt_reset = 1'b1;
        #1;
        check("rst_mid_write", 64'(mgmt_write), 64'(1'b0));
        check("rst_mid_tv", 64'(tv_reset), 64'(1'b1));
        @(posedge mgmt_clk);
        #1;
        cyc++;
        mgmt_reset = 1'b0;
        got_q.delete();
        prev_write = 0; prev_wait = 0; gap_st = 0; stall_left = 0;
        // Synchronizers restart at 0, so boot programs NTSC and then PAL is relaunched.
        expect_seq(1'b0);
        expect_seq(1'b1);
        run_until_idle("rst_mid", 800);
        compare_writes("rst_mid");
        applied_ref = 1'b1;

        // Random standard requests.
        for (int k = 0; k < 6; k++) begin
            newpal = 1'($urandom_range(0, 1));
            rand_wait = 1'($urandom_range(0, 1));
            pal = newpal;
            if (newpal != applied_ref) begin
                expect_seq(newpal);
                run_until_idle($sformatf("rnd%0d", k), 400);
                compare_writes($sformatf("rnd%0d", k));
            end else begin
                idle_quiet($sformatf("rnd%0d", k));
            end
            applied_ref = newpal;
        end

`ifdef PLLRC_LOCK_TIMEOUT_EN
        // Lock never returns: the write sequence restarts every TIMEOUT cycles.
        rand_wait = 0; pll_stuck = 1;
        pal = !applied_ref;
        for (int k = 0; k < 2; k++) begin
            int hs_before;
            hs_before = start_hs_cyc;
            n = 0;
            while (start_hs_cyc == hs_before && n < 400) begin
                step();
                n++;
            end
            check("to_start_seen", 64'(start_hs_cyc != hs_before), 64'(1'b1));
            n = 0;
            while (!(mgmt_write && mgmt_address == 6'd0) && n < 400) begin
                step();
                n++;
            end
            // WAIT_LOCK for TIMEOUT cycles, one WRITE gap cycle, then the strobe.
            check("to_reentry_delay", 64'(cyc - start_hs_cyc), 64'(TIMEOUT + 2));
            check("to_tv_high", 64'(tv_reset), 64'(1'b1));
        end
        pll_stuck = 0;
        got_q.delete();
        exp_q.delete();
        expect_seq(pal);
        run_until_idle("to_final", 400);
        compare_writes("to_final");
        applied_ref = pal;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
